// File: rtl/cam_pkg.sv
// cam_pkg: shared camera-path constants, RGB555 field indices and capture FSM states
package cam_pkg;
  localparam int CAM_DEPTH  = 76800;
  localparam int CAM_ADDR_W = 17;
  localparam int R_HI = 14;
  localparam int R_LO = 10;
  localparam int G_HI = 9;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} cam_state_e;
endpackage

// File: rtl/cam_frame_writer_if.sv
// cam_frame_writer_if: pixel input, capture handshake and frame-buffer write bus; master = writer, slave = environment
interface cam_frame_writer_if import cam_pkg::*; #(
  parameter int ADDR_W = CAM_ADDR_W
);
  logic [14:0]       px_data;
  logic              px_strobe;
  logic              frame_start;
  logic              capture_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              busy;
  logic              frame_done;
  logic              short_frame;
  modport master (
    input  px_data, px_strobe, frame_start, capture_req,
    output mem_addr, mem_data, mem_we, busy, frame_done, short_frame
  );
  modport slave (
    output px_data, px_strobe, frame_start, capture_req,
    input  mem_addr, mem_data, mem_we, busy, frame_done, short_frame
  );
endinterface

// File: rtl/cam_px_convert.sv
// cam_px_convert: RGB555 to 8-bit pixel (px_i in, y_o out); RGB332 by default, gray 2R+5G+B when CAM_WR_GRAY_EN is defined
module cam_px_convert import cam_pkg::*; (
  input  logic [14:0] px_i,
  output logic [7:0]  y_o
);
`ifdef CAM_WR_GRAY_EN
  logic [4:0] r, g, b;
  assign r = px_i[R_HI:R_LO];
  assign g = px_i[G_HI:G_LO];
  assign b = px_i[B_HI:B_LO];
  // peak is 2*31 + 5*31 + 31 = 248, so 8 bits never overflow
  assign y_o = {2'b00, r, 1'b0} + 8'(g) * 8'd5 + 8'(b);
`else
  logic unused_lsbs;
  assign unused_lsbs = ^{px_i[R_LO+1:R_LO], px_i[G_LO+1:G_LO], px_i[B_LO+2:B_LO]};
  assign y_o = {px_i[R_HI -: 3], px_i[G_HI -: 3], px_i[B_HI -: 2]};
`endif
endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: captures one frame per capture_req into a linear frame buffer (pclk, rst, bus.master); gray mode via CAM_WR_GRAY_EN
module cam_frame_writer import cam_pkg::*; #(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input logic pclk,
  input logic rst,
  cam_frame_writer_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  cam_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, base;
  logic [7:0] data_q, data_d, px8;
  logic strb_q, fs_q, strb_rise, fs_rise, active;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, short_q, short_d;
  cam_px_convert u_conv (.px_i(bus.px_data), .y_o(px8));
  assign strb_rise = bus.px_strobe & ~strb_q;
  assign fs_rise   = bus.frame_start & ~fs_q;
  // ARM only moves on a frame-start rise; CAPTURE acts every cycle
  assign active    = (state_q == CAPTURE) || (state_q == ARM && fs_rise);
  // a frame-start rise always restarts the frame at address 0
  assign base      = fs_rise ? '0 : cnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    short_d = short_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.capture_req) begin
          state_d = ARM;
          short_d = 1'b0;
        end
      end
      ARM, CAPTURE: begin
        if (!bus.capture_req) state_d = IDLE;
        else if (active) begin
          state_d = CAPTURE;
          cnt_d   = base;
          if (state_q == CAPTURE && fs_rise && cnt_q != '0) short_d = 1'b1;
          if (strb_rise) begin
            we_d   = 1'b1;
            addr_d = base;
            data_d = px8;
            if (base == LAST) state_d = DONE;
            else cnt_d = base + ADDR_W'(1);
          end
        end
      end
      default: if (!bus.capture_req) state_d = IDLE;
    endcase
  end
  assign busy_d = (state_d == ARM) || (state_d == CAPTURE);
  // rises one cycle after the final write, falls as soon as the release is sampled
  assign done_d = (state_q == DONE) && (state_d == DONE);
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      strb_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      short_q <= short_d;
      strb_q  <= bus.px_strobe;
      fs_q    <= bus.frame_start;
    end
  end
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_we      = we_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.short_frame = short_q;
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: directed table-driven bench for cam_frame_writer with DEPTH=4
module tb_cam_frame_writer;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  cam_frame_writer_if #(.ADDR_W(17)) bus();
  cam_frame_writer #(.DEPTH(4), .ADDR_W(17)) dut (.pclk(pclk), .rst(rst), .bus(bus));
  always #5 pclk = ~pclk;
  always @(negedge pclk) if (bus.mem_we === 1'b1) we_cnt++;
  typedef struct {
    logic [14:0] px;
    logic        fs;
    int          addr;
    int          rgb;
    int          gray;
  } vec_t;
  vec_t tv[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int exp_px(input int rgb, input int gray);
`ifdef CAM_WR_GRAY_EN
    return gray;
`else
    return rgb;
`endif
  endfunction
  task automatic tick();
    @(negedge pclk);
  endtask
  task automatic pixel(input logic [14:0] d, input logic fs, output logic w, output logic [31:0] a, output logic [31:0] q);
    bus.px_data = d;
    bus.px_strobe = 1'b1;
    bus.frame_start = fs;
    tick();
    w = bus.mem_we;
    a = 32'(bus.mem_addr);
    q = 32'(bus.mem_data);
    bus.px_strobe = 1'b0;
    bus.frame_start = 1'b0;
    tick();
  endtask
  initial begin
    logic w;
    logic [31:0] a, q;
    int c0;
    tv[0] = '{15'h7FFF, 1'b1, 0, 8'hFF, 248};
    tv[1] = '{15'h0000, 1'b0, 1, 8'h00, 0};
    tv[2] = '{15'h7C00, 1'b0, 2, 8'hE0, 62};
    tv[3] = '{15'h001F, 1'b0, 3, 8'h03, 31};
    bus.px_data = '0;
    bus.px_strobe = 1'b0;
    bus.frame_start = 1'b0;
    bus.capture_req = 1'b0;
    repeat (2) tick();
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_data", bus.mem_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_short", bus.short_frame, 0);
    rst = 1'b0;
    tick();
    bus.capture_req = 1'b1;
    tick();
    chk("arm_busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      pixel(tv[i].px, tv[i].fs, w, a, q);
      chk("frame_we", w, 1);
      chk("frame_addr", a, tv[i].addr);
      chk("frame_data", q, exp_px(tv[i].rgb, tv[i].gray));
    end
    chk("frame_done", bus.frame_done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_short", bus.short_frame, 0);
    pixel(15'h1234, 1'b1, w, a, q);
    chk("done_ignore_we", w, 0);
    chk("done_we_total", we_cnt, 4);
    chk("done_hold", bus.frame_done, 1);
    bus.capture_req = 1'b0;
    tick();
    chk("done_release", bus.frame_done, 0);
    bus.capture_req = 1'b1;
    tick();
    pixel(15'h7FFF, 1'b1, w, a, q);
    chk("sf_a0", a, 0);
    pixel(15'h0000, 1'b0, w, a, q);
    chk("sf_a1", a, 1);
    pixel(15'h001F, 1'b1, w, a, q);
    chk("sf_restart_we", w, 1);
    chk("sf_restart_addr", a, 0);
    chk("sf_restart_data", q, exp_px(8'h03, 31));
    chk("sf_flag", bus.short_frame, 1);
    pixel(15'h7C00, 1'b0, w, a, q);
    chk("sf_next_addr", a, 1);
    bus.capture_req = 1'b0;
    tick();
    chk("sf_abort_busy", bus.busy, 0);
    chk("sf_sticky", bus.short_frame, 1);
    bus.capture_req = 1'b1;
    tick();
    chk("sf_clear_on_arm", bus.short_frame, 0);
    c0 = we_cnt;
    bus.px_data = 15'h7FFF;
    bus.px_strobe = 1'b1;
    bus.frame_start = 1'b1;
    repeat (5) tick();
    bus.px_strobe = 1'b0;
    bus.frame_start = 1'b0;
    tick();
    chk("hold_one_write", we_cnt - c0, 1);
    pixel(15'h0000, 1'b0, w, a, q);
    chk("hold_next_addr", a, 1);
    bus.capture_req = 1'b0;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.frame_done, 0);
    c0 = we_cnt;
    pixel(15'h7FFF, 1'b0, w, a, q);
    pixel(15'h7FFF, 1'b1, w, a, q);
    chk("abort_no_we", we_cnt - c0, 0);
    bus.capture_req = 1'b1;
    tick();
    pixel(15'h7FFF, 1'b0, w, a, q);
    chk("rearm_wait_we", w, 0);
    chk("rearm_busy", bus.busy, 1);
    pixel(15'h7C00, 1'b1, w, a, q);
    chk("rearm_we", w, 1);
    chk("rearm_addr", a, 0);
    chk("rearm_data", q, exp_px(8'hE0, 62));
    pixel(15'h001F, 1'b0, w, a, q);
    chk("rearm_addr1", a, 1);
    bus.px_data = 15'h7FFF;
    bus.px_strobe = 1'b1;
    tick();
    chk("pre_rst_we", bus.mem_we, 1);
    chk("pre_rst_addr", bus.mem_addr, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_data", bus.mem_data, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.frame_done, 0);
    chk("mid_rst_short", bus.short_frame, 0);
    bus.px_strobe = 1'b0;
    bus.capture_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    c0 = we_cnt;
    pixel(15'h7FFF, 1'b1, w, a, q);
    pixel(15'h7FFF, 1'b1, w, a, q);
    chk("idle_no_we", we_cnt - c0, 0);
    bus.capture_req = 1'b1;
    tick();
    pixel(15'h7FFF, 1'b0, w, a, q);
    chk("post_rst_wait", w, 0);
    pixel(15'h0000, 1'b1, w, a, q);
    chk("post_rst_we", w, 1);
    chk("post_rst_addr", a, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
